// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request/response and data-memory port bundle for the load/store unit
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU request side
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // CPU response side
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;

  // Data-memory side
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  // Load/store unit view
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_write, mem_read
  );

  // CPU plus memory view
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store initiator with sub-word read-modify-write
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t            state_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_write_data_q;
  logic              mem_write_q;
  logic              mem_read_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_error_q;

  logic              req_bad_d;
  logic [4:0]        shift_d;
  logic [DATA_W-1:0] shifted_d;
  logic [DATA_W-1:0] load_ext_d;
  logic [DATA_W-1:0] lane_mask_d;
  logic [DATA_W-1:0] merge_d;

  // Request legality, load lane extraction and store lane merge
  always_comb begin
    req_bad_d   = (bus.req_size == 2'b11) ||
                  (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    shift_d     = {lane_q, 3'b000};
    shifted_d   = bus.mem_read_data >> shift_d;
    load_ext_d  = bus.mem_read_data;
    case (size_q)
      2'b00:   load_ext_d = {{(DATA_W-8){signed_q & shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   load_ext_d = {{(DATA_W-16){signed_q & shifted_d[15]}}, shifted_d[15:0]};
      default: load_ext_d = bus.mem_read_data;
    endcase
    lane_mask_d = (size_q == 2'b00) ? ({{(DATA_W-8){1'b0}}, 8'hFF} << shift_d)
                                    : ({{(DATA_W-16){1'b0}}, 16'hFFFF} << shift_d);
    merge_d     = (bus.mem_read_data & ~lane_mask_d) | ((wdata_q << shift_d) & lane_mask_d);
  end

  // Access sequencer with registered memory strobes and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      lane_q           <= 2'b00;
      size_q           <= 2'b00;
      signed_q         <= 1'b0;
      wdata_q          <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_rdata_q     <= '0;
      resp_error_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            lane_q        <= bus.req_addr[1:0];
            size_q        <= bus.req_size;
            signed_q      <= bus.req_signed;
            wdata_q       <= bus.req_wdata;
            mem_address_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            resp_rdata_q  <= '0;
            resp_error_q  <= 1'b0;
            if (req_bad_d) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              state_q      <= RESP;
            end else if (!bus.req_write) begin
              mem_read_q <= 1'b1;
              state_q    <= LOAD;
            end else if (bus.req_size == 2'b10) begin
              mem_write_q      <= 1'b1;
              mem_write_data_q <= bus.req_wdata;
              state_q          <= STORE;
            end else begin
              mem_read_q <= 1'b1;
              state_q    <= RMW_RD;
            end
          end
        end
        LOAD: begin
          mem_read_q   <= 1'b0;
          resp_rdata_q <= load_ext_d;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        STORE: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RMW_RD: begin
          // Merge straight from the read data so the write strobe follows with no gap
          mem_read_q       <= 1'b0;
          mem_write_q      <= 1'b1;
          mem_write_data_q <= merge_d;
          state_q          <= RMW_WR;
        end
        RMW_WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_read       = mem_read_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] mem [0:1023];

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write committed at the posedge ending the strobe cycle
  assign bus.mem_read_data = mem[bus.mem_address[11:2]];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;
  end

  // Issue one request and follow it until resp_valid, recording the strobes seen
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output int nrd, output int nwr,
                       output logic [31:0] wdat, output logic [31:0] maddr, output logic both);
    lat = -1; nrd = 0; nwr = 0; wdat = '0; maddr = '0; both = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (bus.mem_read) begin nrd++; maddr = bus.mem_address; end
      if (bus.mem_write) begin nwr++; wdat = bus.mem_write_data; maddr = bus.mem_address; end
      if (bus.mem_read && bus.mem_write) both = 1'b1;
      if (bus.resp_valid) begin lat = e; break; end
      @(posedge clk);
    end
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {bus.req_ready, bus.resp_valid, bus.resp_error, bus.mem_read, bus.mem_write});
    end
    checks++;
    if ({bus.resp_rdata, bus.mem_address, bus.mem_write_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.resp_rdata, bus.mem_address, bus.mem_write_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] addrs [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h12, 32'h11};
    logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    logic        sgns  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exps  [6] = '{32'hFFFFFF88, 32'h00000088, 32'h00008877,
                               32'h88776655, 32'hFFFF8877, 32'h00000066};
    int lat, nrd, nwr;
    logic [31:0] wdat, maddr;
    logic both;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, sizes[i], sgns[i], addrs[i], 32'hFFFFFFFF, lat, nrd, nwr, wdat, maddr, both);
      checks++;
      if (bus.resp_rdata !== exps[i] || bus.resp_error !== 1'b0) begin
        errors++;
        $display("FAIL load_data[%0d]: got %h err %b expected %h err 0",
                 i, bus.resp_rdata, bus.resp_error, exps[i]);
      end
      checks++;
      if (lat !== 1 || nrd !== 1 || nwr !== 0 || maddr !== 32'h10) begin
        errors++;
        $display("FAIL load_timing[%0d]: got lat %0d rd %0d wr %0d addr %h expected lat 1 rd 1 wr 0 addr 00000010",
                 i, lat, nrd, nwr, maddr);
      end
      ack();
    end
  endtask

  task automatic test_stores();
    logic [31:0] addrs [3] = '{32'h11, 32'h20, 32'h22};
    logic [1:0]  sizes [3] = '{2'b00, 2'b10, 2'b01};
    logic [31:0] wds   [3] = '{32'h000000AB, 32'hDEADBEEF, 32'h1234CAFE};
    logic [31:0] expw  [3] = '{32'h8877AB55, 32'hDEADBEEF, 32'hCAFEBEEF};
    int          expl  [3] = '{2, 1, 2};
    int          exprd [3] = '{1, 0, 1};
    int lat, nrd, nwr;
    logic [31:0] wdat, maddr;
    logic both;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, sizes[i], 1'b0, addrs[i], wds[i], lat, nrd, nwr, wdat, maddr, both);
      checks++;
      if (wdat !== expw[i] || maddr !== {addrs[i][31:2], 2'b00}) begin
        errors++;
        $display("FAIL store_wdata[%0d]: got %h @%h expected %h", i, wdat, maddr, expw[i]);
      end
      checks++;
      if (lat !== expl[i] || nrd !== exprd[i] || nwr !== 1 || both !== 1'b0) begin
        errors++;
        $display("FAIL store_timing[%0d]: got lat %0d rd %0d wr %0d both %b expected lat %0d rd %0d wr 1 both 0",
                 i, lat, nrd, nwr, both, expl[i], exprd[i]);
      end
      checks++;
      if (bus.resp_rdata !== 32'h0 || bus.resp_error !== 1'b0) begin
        errors++;
        $display("FAIL store_resp[%0d]: got %h err %b expected 0 err 0", i, bus.resp_rdata, bus.resp_error);
      end
      ack();
      checks++;
      if (mem[addrs[i][11:2]] !== expw[i]) begin
        errors++;
        $display("FAIL store_mem[%0d]: got %h expected %h", i, mem[addrs[i][11:2]], expw[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        ws    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sizes [4] = '{2'b01, 2'b11, 2'b10, 2'b01};
    logic [31:0] addrs [4] = '{32'h11, 32'h10, 32'h12, 32'h13};
    int lat, nrd, nwr;
    logic [31:0] wdat, maddr;
    logic both;
    for (int i = 0; i < 4; i++) begin
      issue(ws[i], sizes[i], 1'b1, addrs[i], 32'h5A5A5A5A, lat, nrd, nwr, wdat, maddr, both);
      checks++;
      if (bus.resp_error !== 1'b1 || bus.resp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL error_resp[%0d]: got err %b data %h expected err 1 data 0",
                 i, bus.resp_error, bus.resp_rdata);
      end
      checks++;
      if (lat !== 0 || nrd !== 0 || nwr !== 0) begin
        errors++;
        $display("FAIL error_timing[%0d]: got lat %0d rd %0d wr %0d expected lat 0 rd 0 wr 0",
                 i, lat, nrd, nwr);
      end
      ack();
    end
    checks++;
    if (mem[4] !== 32'h8877AB55 || mem[8] !== 32'hCAFEBEEF) begin
      errors++;
      $display("FAIL error_nowrite: got %h %h expected 8877ab55 cafebeef", mem[4], mem[8]);
    end
  endtask

  task automatic test_backpressure();
    int lat, nrd, nwr;
    logic [31:0] wdat, maddr;
    logic both;
    logic seen;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, nrd, nwr, wdat, maddr, both);
    // Queue a second request that must wait until the response handshake is done
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.resp_valid, bus.resp_error, bus.req_ready} !== 3'b100 || bus.resp_rdata !== 32'hCAFEBEEF) begin
        errors++;
        $display("FAIL hold[%0d]: got v/e/rdy %b data %h expected 100 cafebeef",
                 i, {bus.resp_valid, bus.resp_error, bus.req_ready}, bus.resp_rdata);
      end
    end
    ack();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake_edge: got rdy %b valid %b expected rdy 1 valid 0", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL next_accept: got rdy %b expected 0", bus.req_ready);
    end
    seen = 1'b0;
    for (int e = 0; e < 10 && !seen; e++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || bus.resp_rdata !== 32'h8877AB55) begin
      errors++;
      $display("FAIL queued_load: got seen %b data %h expected seen 1 data 8877ab55", seen, bus.resp_rdata);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    int lat, nrd, nwr;
    logic [31:0] wdat, maddr;
    logic both;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h000000CC;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_read !== 1'b1) begin
      errors++;
      $display("FAIL rmw_rd_entered: got mem_read %b expected 1", bus.mem_read);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.resp_valid, bus.req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset: got rd/wr/v/rdy %b expected 0001",
               {bus.mem_read, bus.mem_write, bus.resp_valid, bus.req_ready});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem[4] !== 32'h8877AB55 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon: got mem %h rdy %b expected 8877ab55 rdy 1", mem[4], bus.req_ready);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, wdat, maddr, both);
    checks++;
    if (bus.resp_rdata !== 32'h00000055 || lat !== 1) begin
      errors++;
      $display("FAIL post_reset_load: got %h lat %0d expected 00000055 lat 1", bus.resp_rdata, lat);
    end
    ack();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h88776655;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
